// File: rtl/id_ex_alu_issue_if.sv
// ID/EX ALU issue bundle: decode-side inputs and registered EX-stage outputs.
interface id_ex_alu_issue_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned COUNT_W = 16
);
  logic [31:0]        InstrD;
  logic               ValidD;
  logic [XLEN-1:0]    RD1D;
  logic [XLEN-1:0]    RD2D;
  logic               StallE;
  logic               FlushE;
  logic [2:0]         ALUControlE;
  logic [XLEN-1:0]    SrcAE;
  logic [XLEN-1:0]    SrcBE;
  logic [XLEN-1:0]    WriteDataE;
  logic               RegWriteE;
  logic               MemWriteE;
  logic               ResultSrcE;
  logic               BranchE;
  logic               ValidE;
  logic               IllegalE;
  logic [COUNT_W-1:0] IssueCount;

  modport master (
    output InstrD, ValidD, RD1D, RD2D, StallE, FlushE,
    input  ALUControlE, SrcAE, SrcBE, WriteDataE, RegWriteE, MemWriteE,
    input  ResultSrcE, BranchE, ValidE, IllegalE, IssueCount
  );

  modport slave (
    input  InstrD, ValidD, RD1D, RD2D, StallE, FlushE,
    output ALUControlE, SrcAE, SrcBE, WriteDataE, RegWriteE, MemWriteE,
    output ResultSrcE, BranchE, ValidE, IllegalE, IssueCount
  );
endinterface

// File: rtl/id_ex_alu_issue.sv
// Decodes the ID-stage instruction for the ALU and registers it across the ID/EX boundary,
// with flush/stall control and a wrapping count of issued instructions.
module id_ex_alu_issue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned COUNT_W = 16
) (
  input logic                clk,
  input logic                reset,
  id_ex_alu_issue_if.slave   bus
);
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluSll  = 3'b110;
  localparam logic [2:0] AluPass = 3'b111;

  typedef struct packed {
    logic [2:0]      alu;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] wdata;
    logic            regwr;
    logic            memwr;
    logic            ressrc;
    logic            branch;
    logic            valid;
    logic            illegal;
  } pipe_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic            w_f7b5;
  logic            w_f7zero;
  logic [2:0]      w_alu;
  logic            w_alusrc, w_regwr, w_memwr, w_ressrc, w_branch, w_lui, w_store, w_illegal;
  logic [XLEN-1:0] w_imm;
  pipe_t           w_next;
  pipe_t           r_pipe;
  logic [COUNT_W-1:0] r_count;

  assign w_opcode = bus.InstrD[6:0];
  assign w_f3     = bus.InstrD[14:12];
  assign w_f7b5   = bus.InstrD[30];
  assign w_f7zero = (bus.InstrD[31:25] == 7'd0);

  // R-type and I-ALU share the funct3 map; only add/sub selection differs
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic sub, input logic f7z);
    logic [3:0] res;  // {illegal, alu}
    res = {1'b0, AluAdd};
    case (f3)
      3'b000:  res = {1'b0, sub ? AluSub : AluAdd};
      3'b111:  res = {1'b0, AluAnd};
      3'b110:  res = {1'b0, AluOr};
      3'b010:  res = {1'b0, AluSlt};
      3'b001:  res = f7z ? {1'b0, AluSll} : {1'b1, AluAdd};
      default: res = {1'b1, AluAdd};
    endcase
    return res;
  endfunction

  always_comb begin
    w_alu     = AluAdd;
    w_alusrc  = 1'b0;
    w_regwr   = 1'b0;
    w_memwr   = 1'b0;
    w_ressrc  = 1'b0;
    w_branch  = 1'b0;
    w_lui     = 1'b0;
    w_store   = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_regwr = 1'b1;
        {w_illegal, w_alu} = alu_f3(w_f3, w_f7b5, w_f7zero);
      end
      7'b0010011: begin
        w_regwr  = 1'b1;
        w_alusrc = 1'b1;
        {w_illegal, w_alu} = alu_f3(w_f3, 1'b0, w_f7zero);
      end
      7'b0000011: begin
        w_illegal = (w_f3 != 3'b010);
        w_alusrc  = 1'b1;
        w_regwr   = 1'b1;
        w_ressrc  = 1'b1;
      end
      7'b0100011: begin
        w_illegal = (w_f3 != 3'b010);
        w_alusrc  = 1'b1;
        w_memwr   = 1'b1;
        w_store   = 1'b1;
      end
      7'b1100011: begin
        w_illegal = (w_f3 != 3'b000);
        w_alu     = AluSub;
        w_branch  = 1'b1;
      end
      7'b0110111: begin
        w_alu    = AluPass;
        w_alusrc = 1'b1;
        w_regwr  = 1'b1;
        w_lui    = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_alu    = AluAdd;
      w_alusrc = 1'b0;
      w_regwr  = 1'b0;
      w_memwr  = 1'b0;
      w_ressrc = 1'b0;
      w_branch = 1'b0;
      w_lui    = 1'b0;
      w_store  = 1'b0;
    end
  end

  always_comb begin
    if (w_lui) begin
      w_imm = {bus.InstrD[31:12], 12'b0};
    end else if (w_store) begin
      w_imm = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
    end else begin
      w_imm = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]};
    end
  end

  always_comb begin
    w_next = '0;
    if (bus.ValidD) begin
      w_next.alu     = w_alu;
      w_next.src_a   = w_lui ? '0 : bus.RD1D;
      w_next.src_b   = w_alusrc ? w_imm : bus.RD2D;
      w_next.wdata   = bus.RD2D;
      w_next.regwr   = w_regwr;
      w_next.memwr   = w_memwr;
      w_next.ressrc  = w_ressrc;
      w_next.branch  = w_branch;
      w_next.valid   = 1'b1;
      w_next.illegal = w_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe  <= '0;
      r_count <= '0;
    end else if (bus.FlushE) begin
      r_pipe  <= '0;
    end else if (!bus.StallE) begin
      r_pipe  <= w_next;
      r_count <= r_count + COUNT_W'(bus.ValidD);
    end
  end

  assign bus.ALUControlE = r_pipe.alu;
  assign bus.SrcAE       = r_pipe.src_a;
  assign bus.SrcBE       = r_pipe.src_b;
  assign bus.WriteDataE  = r_pipe.wdata;
  assign bus.RegWriteE   = r_pipe.regwr;
  assign bus.MemWriteE   = r_pipe.memwr;
  assign bus.ResultSrcE  = r_pipe.ressrc;
  assign bus.BranchE     = r_pipe.branch;
  assign bus.ValidE      = r_pipe.valid;
  assign bus.IllegalE    = r_pipe.illegal;
  assign bus.IssueCount  = r_count;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed self-checking bench for id_ex_alu_issue with a 4-bit issue counter.
module tb_id_ex_alu_issue;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned COUNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  id_ex_alu_issue_if #(.XLEN(XLEN), .COUNT_W(COUNT_W)) bus ();

  id_ex_alu_issue #(.XLEN(XLEN), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2);
    bus.InstrD = instr;
    bus.RD1D   = rd1;
    bus.RD2D   = rd2;
    bus.ValidD = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    bus.InstrD = '0;
    bus.ValidD = 1'b0;
    bus.RD1D   = '0;
    bus.RD2D   = '0;
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.ValidE), 32'd0);
    check_eq("rst_count", 32'(bus.IssueCount), 32'd0);
    check_eq("rst_srca", bus.SrcAE, 32'd0);
    #2 reset = 1'b0;

    drive(32'h002081B3, 32'd5, 32'd7);  // add x3,x1,x2
    step();
    check_eq("add_alu", 32'(bus.ALUControlE), 32'd0);
    check_eq("add_srca", bus.SrcAE, 32'd5);
    check_eq("add_srcb", bus.SrcBE, 32'd7);
    check_eq("add_regwr", 32'(bus.RegWriteE), 32'd1);
    check_eq("add_valid", 32'(bus.ValidE), 32'd1);
    check_eq("add_count", 32'(bus.IssueCount), 32'd1);

    drive(32'h402081B3, 32'd5, 32'd7);  // sub
    step();
    check_eq("sub_alu", 32'(bus.ALUControlE), 32'd1);
    check_eq("sub_srcb", bus.SrcBE, 32'd7);

    drive(32'hFFB00093, 32'd5, 32'd7);  // addi x1,x0,-5
    step();
    check_eq("addi_alu", 32'(bus.ALUControlE), 32'd0);
    check_eq("addi_srcb", bus.SrcBE, 32'hFFFFFFFB);

    drive(32'h123452B7, 32'd5, 32'd7);  // lui
    step();
    check_eq("lui_alu", 32'(bus.ALUControlE), 32'd7);
    check_eq("lui_srca", bus.SrcAE, 32'd0);
    check_eq("lui_srcb", bus.SrcBE, 32'h12345000);
    check_eq("lui_regwr", 32'(bus.RegWriteE), 32'd1);

    drive(32'h0020A423, 32'd5, 32'hAA);  // sw x2,8(x1)
    step();
    check_eq("sw_alu", 32'(bus.ALUControlE), 32'd0);
    check_eq("sw_srcb", bus.SrcBE, 32'd8);
    check_eq("sw_wdata", bus.WriteDataE, 32'hAA);
    check_eq("sw_memwr", 32'(bus.MemWriteE), 32'd1);
    check_eq("sw_regwr", 32'(bus.RegWriteE), 32'd0);
    check_eq("sw_count", 32'(bus.IssueCount), 32'd5);

    drive(32'h002081B3, 32'd1, 32'd2);
    step();
    check_eq("pre_stall_count", 32'(bus.IssueCount), 32'd6);
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h402081B3 + 32'(i), 32'd100 + 32'(i), 32'd200);
      step();
      check_eq("stall_alu", 32'(bus.ALUControlE), 32'd0);
      check_eq("stall_srcb", bus.SrcBE, 32'd2);
      check_eq("stall_count", 32'(bus.IssueCount), 32'd6);
    end
    bus.FlushE = 1'b1;
    step();
    check_eq("flush_valid", 32'(bus.ValidE), 32'd0);
    check_eq("flush_regwr", 32'(bus.RegWriteE), 32'd0);
    check_eq("flush_srca", bus.SrcAE, 32'd0);
    check_eq("flush_count", 32'(bus.IssueCount), 32'd6);
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;

    drive(32'h40001033, 32'd5, 32'd7);  // R-type sll with funct7=0x20
    step();
    check_eq("ill_flag", 32'(bus.IllegalE), 32'd1);
    check_eq("ill_alu", 32'(bus.ALUControlE), 32'd0);
    check_eq("ill_regwr", 32'(bus.RegWriteE), 32'd0);
    check_eq("ill_valid", 32'(bus.ValidE), 32'd1);
    check_eq("ill_count", 32'(bus.IssueCount), 32'd7);

    drive(32'h0000A083, 32'd16, 32'd7);  // lw x1,0(x1)
    step();
    check_eq("lw_ressrc", 32'(bus.ResultSrcE), 32'd1);
    check_eq("lw_srcb", bus.SrcBE, 32'd0);
    check_eq("lw_illegal", 32'(bus.IllegalE), 32'd0);

    drive(32'h00208063, 32'd5, 32'd9);  // beq x1,x2
    step();
    check_eq("beq_alu", 32'(bus.ALUControlE), 32'd1);
    check_eq("beq_branch", 32'(bus.BranchE), 32'd1);
    check_eq("beq_srcb", bus.SrcBE, 32'd9);
    check_eq("beq_regwr", 32'(bus.RegWriteE), 32'd0);

    bus.ValidD = 1'b0;
    step();
    check_eq("bubble_valid", 32'(bus.ValidE), 32'd0);
    check_eq("bubble_srcb", bus.SrcBE, 32'd0);
    check_eq("bubble_count", 32'(bus.IssueCount), 32'd9);

    // Reset mid-stall, between clock edges
    drive(32'h002081B3, 32'd5, 32'd7);
    bus.StallE = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_count", 32'(bus.IssueCount), 32'd0);
    check_eq("async_rst_valid", 32'(bus.ValidE), 32'd0);
    check_eq("async_rst_srcb", bus.SrcBE, 32'd0);
    reset      = 1'b0;
    bus.StallE = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(32'hFFB00093, 32'd0, 32'd0);
      step();
      if (i == 14) check_eq("count_15", 32'(bus.IssueCount), 32'd15);
      if (i == 15) check_eq("count_wrap0", 32'(bus.IssueCount), 32'd0);
    end
    check_eq("count_wrap1", 32'(bus.IssueCount), 32'd1);
    check_eq("post_rst_valid", 32'(bus.ValidE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- Producer side of the execute-stage ALU interface.
- Decodes the ID-stage instruction into the ALU's 3-bit operation code, operand selection and immediate.
- Registers everything into the ID/EX pipeline boundary with stall and flush control, so the ALU sees stable SrcAE/SrcBE/ALUControlE each cycle.
- Also keeps a wrapping count of issued (valid) instructions for performance monitoring.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- COUNT_W, 16, width of the IssueCount counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- InstrD  in  32  instruction in decode
- ValidD  in  1  InstrD is a real instruction
- RD1D  in  XLEN  register file read port 1
- RD2D  in  XLEN  register file read port 2
- StallE  in  1  hold ID/EX register contents
- FlushE  in  1  replace ID/EX contents with a bubble
- ALUControlE  out  3  ALU operation code
- SrcAE  out  XLEN  ALU operand A
- SrcBE  out  XLEN  ALU operand B
- WriteDataE  out  XLEN  store data (RD2D)
- RegWriteE  out  1  register file write enable
- MemWriteE  out  1  store enable
- ResultSrcE  out  1  1 = result comes from load data
- BranchE  out  1  beq; consumer uses the ALU Zero flag
- ValidE  out  1  EX-stage slot holds an instruction
- IllegalE  out  1  unsupported encoding captured
- IssueCount  out  COUNT_W  count of captured valid instructions

Behaviour:
- ALU codes: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll, 111 pass B.
- Decode is combinational from InstrD. Opcode InstrD[6:0], funct3 [14:12], funct7b5 [30].
- 0110011, R-type, ALUSrc=0, RegWrite=1:
  - f3 000 → add (funct7b5=0) or sub (funct7b5=1)
  - f3 111 → and; 110 → or; 010 → slt
  - f3 001 → sll, legal only when funct7=0
  - other f3 illegal
- 0010011, I-ALU, ALUSrc=1, RegWrite=1:
  - f3 000 → add (bit30 ignored); 111 → and; 110 → or; 010 → slt
  - f3 001 → sll, legal only when InstrD[31:25]=0
  - other f3 illegal
- 0000011 with f3 010 (lw): add, ALUSrc=1, RegWrite=1, ResultSrc=1.
- 0100011 with f3 010 (sw): add, ALUSrc=1, MemWrite=1, S-immediate.
- 1100011 with f3 000 (beq): sub, ALUSrc=0, Branch=1.
- 0110111 (lui): pass B, SrcB = {InstrD[31:12], 12'b0}, SrcA = 0, RegWrite=1.
- Immediates:
  - I: sign-extend InstrD[31:20]
  - S: sign-extend {InstrD[31:25], InstrD[11:7]}
  - Branch target generation is not this block's job.
- Illegal decode: ALUControl 000, all enables 0, IllegalE=1, ValidE follows ValidD.
- Operand assignment: SrcAE = RD1D except lui. SrcBE = ALUSrc ? imm : RD2D. WriteDataE = RD2D.
- ValidD=0 decodes as a bubble.
- Bubble = ValidE 0, IllegalE 0, all enables 0, ALUControlE 000, SrcAE/SrcBE/WriteDataE 0.
- Register update on each rising edge, priority reset > FlushE > StallE > load:
  - FlushE=1 → bubble, even if StallE=1.
  - StallE=1 (no flush) → all outputs hold.
  - Otherwise → load decoded values.
  - Latency: exactly 1 cycle from InstrD to E outputs.
- IssueCount:
  - Increments by 1 on a load cycle with ValidD=1, including illegal instructions.
  - No increment on stall, flush or bubble.
  - Wraps from 2^COUNT_W−1 to 0.
- Reset:
  - Asserted at any time, including mid-stall, forces all outputs to bubble values and IssueCount to 0 immediately, without waiting for a clock edge.
  - After deassertion, the first rising edge loads normally.

Test Plan:
- Reset, then InstrD=0x002081B3 (add x3,x1,x2), RD1D=5, RD2D=7, ValidD=1 → next cycle ALUControlE=000, SrcAE=5, SrcBE=7, RegWriteE=1, ValidE=1, IssueCount=1.
- InstrD=0x402081B3 (sub), then 0xFFB00093 (addi x1,x0,-5) → ALUControlE=001, SrcBE=RD2D; then ALUControlE=000, SrcBE=0xFFFFFFFB.
- InstrD=0x123452B7 (lui), then 0x0020A423 (sw x2,8(x1)) with RD2D=0xAA → lui gives ALUControlE=111, SrcAE=0, SrcBE=0x12345000; sw gives ALUControlE=000, SrcBE=8, WriteDataE=0xAA, MemWriteE=1, RegWriteE=0.
- Load add, then StallE=1 for 3 cycles with InstrD changing → outputs and IssueCount frozen. Then assert StallE=1 and FlushE=1 together → bubble next edge, IssueCount unchanged.
- InstrD with opcode 0110011, f3 001, funct7=0x20 → IllegalE=1, ALUControlE=000, RegWriteE=0, IssueCount increments.
- COUNT_W=4: issue 17 valid instructions → IssueCount reads 1. Assert reset between edges → outputs and count 0 before the next rising edge.
